serie_paralelo_rx: RTL

//  Receive-side serial-to-parallel converter of the PHY link; reverse of the TX paralelo-serie block.

---
 rtl/serie_paralelo_rx.sv | 90 +++++++++
 1 files changed

// File: rtl/serie_paralelo_rx.sv
// serie_paralelo_rx: serial-to-parallel receiver; COMMA-based byte alignment, link qualification, byte forwarding.
// Ports:
//   clk_8f    in   bit-rate clock, rising edge
//   reset     in   asynchronous active-low reset
//   data_inS  in   serial data, MSB first
//   data_outP out  last non-COMMA byte received while ACTIVE
//   valid_out out  data_outP holds a byte from the current byte slot
//   byte_strb out  one-cycle pulse after each aligned byte boundary
//   active    out  link aligned and qualified
// Macro SER2PAR_REALIGN_EN: a non-COMMA byte while ALIGNED restarts the bit-level hunt.
module serie_paralelo_rx #(
  parameter logic [7:0] COMMA = 8'hBC,
  parameter int COMMA_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_inS,
  output logic [7:0] data_outP,
  output logic       valid_out,
  output logic       byte_strb,
  output logic       active
);
  typedef enum logic [1:0] {SEARCH, ALIGNED, ACTIVE} state_t;
  localparam logic [3:0] CNT_TGT = 4'(COMMA_COUNT);
  state_t r_state, w_state_nx;
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt, w_bit_nx;
  logic [3:0] r_comma_cnt, w_cnt_nx;
  logic [7:0] r_data, w_data_nx, w_win;
  logic r_valid, w_valid_nx, r_strb, w_comma, w_bound;
  assign w_win = {r_shift, data_inS};
  assign w_comma = w_win == COMMA;
  assign w_bound = r_state != SEARCH && r_bit_cnt == 3'd7;
  always_comb begin
    w_state_nx = r_state;
    w_bit_nx = r_bit_cnt + 3'd1;
    w_cnt_nx = r_comma_cnt;
    w_data_nx = r_data;
    w_valid_nx = r_valid;
    unique case (r_state)
      SEARCH: begin
        // bit counter parked at 0 so the bit after a found COMMA is the next MSB
        w_bit_nx = 3'd0;
        if (w_comma) begin
          w_cnt_nx = 4'd1;
          w_state_nx = CNT_TGT == 4'd1 ? ACTIVE : ALIGNED;
        end
      end
      ALIGNED: if (w_bound) begin
        if (w_comma) begin
          w_cnt_nx = r_comma_cnt + 4'd1;
          w_state_nx = r_comma_cnt + 4'd1 == CNT_TGT ? ACTIVE : ALIGNED;
        end else begin
          w_cnt_nx = 4'd0;
`ifdef SER2PAR_REALIGN_EN
          w_state_nx = SEARCH;
`endif
        end
      end
      ACTIVE: if (w_bound) begin
        w_valid_nx = !w_comma;
        w_data_nx = w_comma ? r_data : w_win;
      end
      default: w_state_nx = SEARCH;
    endcase
  end
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      r_state <= SEARCH;
      r_shift <= '0;
      r_bit_cnt <= '0;
      r_comma_cnt <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_strb <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_win[6:0];
      r_bit_cnt <= w_bit_nx;
      r_comma_cnt <= w_cnt_nx;
      r_data <= w_data_nx;
      r_valid <= w_valid_nx;
      r_strb <= w_bound;
    end
  end
  assign data_outP = r_data;
  assign valid_out = r_valid;
  assign byte_strb = r_strb;
  assign active = r_state == ACTIVE;
endmodule
